pio_poll_master: RTL and testbench
==================================

Name: pio_poll_master

Overview:
- Avalon-MM read initiator that periodically polls a single-register PIO-style input slave (e.g. a button/switch or difficulty-select port) and presents the latest value to fabric logic.
- Emits a one-cycle change pulse whenever the polled value differs from the previous sample, so game/control logic can react without a CPU.
- Sits between the Avalon interconnect (as a master) and user logic; the polled slave uses fixed read latency and has no readdatavalid.

Parameters:
- ADDR_WIDTH, 2, width of avm_address.
- DATA_WIDTH, 32, width of avm_readdata and value.
- POLL_ADDR, 0, address driven on every read.
- PERIOD, 1000, cycles from the end of one transaction to the next request; legal range 1..2^16.
- READ_LATENCY, 1, fixed slave read latency in cycles; legal range 0..3.
- TIMEOUT, 255, waitrequest cycles before timeout_err is set; legal range 1..2^16.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  polling enabled while high
- force_poll  in  1  single-cycle request to poll at the next opportunity
- clear_err  in  1  clears timeout_err
- avm_address  out  ADDR_WIDTH  read address; equals POLL_ADDR whenever avm_read=1
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_WIDTH  slave read data
- value  out  DATA_WIDTH  last captured sample
- valid  out  1  high once at least one sample has been captured since reset
- change  out  1  one-cycle pulse when a new sample differs from value
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky waitrequest-timeout flag

Behaviour:
- Reset values (asynchronous): all outputs 0, avm_address = POLL_ADDR, FSM = IDLE, period counter = 0, pend = 0, wait counter = 0, latency counter = 0.
- All outputs are registered.
- IDLE:
  - Period counter increments each cycle while enable=1, and holds while enable=0.
  - Move to REQ when enable=1 and the counter equals PERIOD-1, or when pend=1 (regardless of enable).
  - The counter resets to 0 on leaving IDLE.
- force_poll:
  - Sets pend in any state.
  - pend clears on entry to REQ.
  - A force_poll arriving during REQ/LAT causes exactly one additional poll after the current one; multiple pulses collapse to one.
- REQ:
  - avm_read=1, avm_address=POLL_ADDR.
  - Held strictly stable until a clock edge with avm_waitrequest=0 (acceptance edge).
  - After acceptance: go to LAT; if READ_LATENCY=0, go to CAP and sample readdata at the acceptance edge.
- Wait counter and timeout:
  - Counts edges in REQ with avm_waitrequest=1.
  - When the count reaches TIMEOUT, set timeout_err.
  - The read is never aborted (Avalon hold rule); the counter saturates.
- LAT:
  - avm_read=0.
  - Counts READ_LATENCY-1 further cycles.
  - avm_readdata is sampled at edge acceptance+READ_LATENCY.
- CAP (single cycle, combined with the sample edge):
  - value <= sample; valid <= 1.
  - change <= valid_old & (sample != value_old), for exactly one cycle.
  - Return to IDLE.
  - The first sample after reset never pulses change.
- enable deasserted mid-transaction: the transaction completes and value updates; the FSM then waits in IDLE.
- clear_err:
  - Clears timeout_err.
  - If clear_err and a new timeout occur on the same edge, set wins.
- Reset mid-transaction: immediate return to reset values, with avm_read=0 asynchronously. The slave-side consequence is accepted.
- Back-to-back operation: minimum spacing between avm_read rising edges is PERIOD + READ_LATENCY + 1 cycles with waitrequest=0.
- No arithmetic beyond counters. Counters are sized by $clog2 of their parameter and never wrap.

Test Plan:
- PERIOD=4, READ_LATENCY=1, waitrequest=0, enable=1, readdata=0x5 → first avm_read pulse 1 cycle wide at cycle 4 after reset release; value=0x5 and valid=1 two cycles later; change stays 0.
- Following poll with readdata=0x7 → change=1 for exactly one cycle, value=0x7; next poll with readdata still 0x7 → change stays 0.
- avm_waitrequest held high 5 cycles with readdata=0x3 → avm_read and avm_address stable for 6 cycles; value=0x3 one cycle after acceptance; TIMEOUT=3 → timeout_err=1 and held; clear_err pulse → 0.
- enable=0, force_poll pulsed twice during one poll → exactly one additional poll, then no further avm_read.
- Reset asserted while in LAT → avm_read, valid, value and change go to 0 immediately; with enable=1 after release, the first poll occurs PERIOD cycles after release.
- READ_LATENCY=0 and =3 variants → readdata sampled at edge acceptance+0 / +3; the wrong-edge value (different data driven) is never captured.

Source files
------------

// File: rtl/pio_poll_master.sv
// Avalon-MM read master that periodically polls one fixed-latency PIO register and
// publishes the latest sample, a one-cycle change pulse and a sticky stall-timeout flag.
module pio_poll_master #(
    parameter int          ADDR_WIDTH   = 2,
    parameter int          DATA_WIDTH   = 32,
    parameter int unsigned POLL_ADDR    = 0,
    parameter int          PERIOD       = 1000,
    parameter int          READ_LATENCY = 1,
    parameter int          TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  force_poll,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  valid,
    output logic                  change,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam int LCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [PCNT_W-1:0]     PERIOD_LAST  = PCNT_W'(PERIOD - 1);
    localparam logic [WCNT_W-1:0]     TIMEOUT_CNT  = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0]     TIMEOUT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [LCNT_W-1:0]     LAT_LAST     = LCNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_VAL     = ADDR_WIDTH'(POLL_ADDR);

    typedef enum logic [1:0] {IDLE, REQ, LAT} state_t;

    state_t                state_reg, state_next;
    logic [PCNT_W-1:0]     period_cnt_reg, period_cnt_next;
    logic [WCNT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [LCNT_W-1:0]     lat_cnt_reg, lat_cnt_next;
    logic                  pend_reg, pend_next;
    logic [DATA_WIDTH-1:0] value_reg, value_next;
    logic                  valid_reg, valid_next;
    logic                  change_reg, change_next;
    logic                  busy_reg, busy_next;
    logic                  read_reg, read_next;
    logic                  timeout_reg, timeout_next;
    logic                  capture;
    logic                  err_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            period_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            lat_cnt_reg    <= '0;
            pend_reg       <= 1'b0;
            value_reg      <= '0;
            valid_reg      <= 1'b0;
            change_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            read_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            period_cnt_reg <= period_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            lat_cnt_reg    <= lat_cnt_next;
            pend_reg       <= pend_next;
            value_reg      <= value_next;
            valid_reg      <= valid_next;
            change_reg     <= change_next;
            busy_reg       <= busy_next;
            read_reg       <= read_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        period_cnt_next = period_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        lat_cnt_next    = lat_cnt_reg;
        pend_next       = pend_reg | force_poll;
        value_next      = value_reg;
        valid_next      = valid_reg;
        change_next     = 1'b0;
        capture         = 1'b0;
        err_set         = 1'b0;

        case (state_reg)
            IDLE: begin
                if ((enable && period_cnt_reg == PERIOD_LAST) || pend_reg) begin
                    state_next      = REQ;
                    period_cnt_next = '0;
                    wait_cnt_next   = '0;
                    pend_next       = 1'b0;
                end else if (enable) begin
                    period_cnt_next = period_cnt_reg + 1'b1;
                end
            end
            REQ: begin
                // The request is never withdrawn; a stall only saturates the counter.
                if (avm_waitrequest) begin
                    if (wait_cnt_reg != TIMEOUT_CNT) begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                        err_set       = (wait_cnt_reg == TIMEOUT_LAST);
                    end
                end else begin
                    lat_cnt_next = '0;
                    if (READ_LATENCY == 0) begin
                        capture = 1'b1;
                    end else begin
                        state_next = LAT;
                    end
                end
            end
            LAT: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    capture = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (capture) begin
            state_next  = IDLE;
            value_next  = avm_readdata;
            valid_next  = 1'b1;
            change_next = valid_reg && (avm_readdata != value_reg);
        end

        // A timeout detected on the same edge as clear_err takes priority.
        timeout_next = err_set ? 1'b1 : (clear_err ? 1'b0 : timeout_reg);
        read_next    = (state_next == REQ);
        busy_next    = (state_next != IDLE);
    end

    assign avm_address = ADDR_VAL;
    assign avm_read    = read_reg;
    assign value       = value_reg;
    assign valid       = valid_reg;
    assign change      = change_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_reg;
endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: three latency variants share one stimulus stream and are each
// tracked by a timestamp-based behavioural model, plus directed scenario checks on latency 1.
module tb_pio_poll_master;
    localparam int            PERIOD  = 4;
    localparam int            TIMEOUT = 3;
    localparam int            DW      = 32;
    localparam int            AW      = 2;
    localparam logic [AW-1:0] PADDR   = 2'd2;
    localparam int            N       = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          force_poll;
    logic          clear_err;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;

    logic [AW-1:0] addr_w   [N];
    logic          read_w   [N];
    logic [DW-1:0] value_w  [N];
    logic          valid_w  [N];
    logic          change_w [N];
    logic          busy_w   [N];
    logic          terr_w   [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_read(input int idx, output int n);
        n = 0;
        while (read_w[idx] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk1($sformatf("wait_read%0d", idx), read_w[idx], 1'b1);
    endtask

    task automatic count_rises(input int idx, input int cycles, output int rises);
        logic prev;
        rises = 0;
        prev  = read_w[idx];
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (read_w[idx] && !prev) rises++;
            prev = read_w[idx];
        end
    endtask

    // Distinct data on every cycle around acceptance: only the edge acceptance+lat may be captured.
    task automatic lat_check(input int idx, input int lat);
        int n;
        wait_read(idx, n);
        for (int k = 0; k < 5; k++) begin
            avm_readdata = 32'hA0 + 32'(k);
            tick();
        end
        chk($sformatf("lat%0d_capture", lat), value_w[idx], 32'hA0 + 32'(lat));
        $display("txn lat_check inst=%0d latency=%0d value=%0h", idx, lat, value_w[idx]);
    endtask

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int RL = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);

        pio_poll_master #(
            .ADDR_WIDTH  (AW),
            .DATA_WIDTH  (DW),
            .POLL_ADDR   (2),
            .PERIOD      (PERIOD),
            .READ_LATENCY(RL),
            .TIMEOUT     (TIMEOUT)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .enable         (enable),
            .force_poll     (force_poll),
            .clear_err      (clear_err),
            .avm_address    (addr_w[gi]),
            .avm_read       (read_w[gi]),
            .avm_waitrequest(avm_waitrequest),
            .avm_readdata   (avm_readdata),
            .value          (value_w[gi]),
            .valid          (valid_w[gi]),
            .change         (change_w[gi]),
            .busy           (busy_w[gi]),
            .timeout_err    (terr_w[gi])
        );

        // Reference: a poll is outstanding (m_txn) and either still requesting (m_req)
        // or waiting for the edge numbered m_acc + RL, at which readdata is taken.
        bit [DW-1:0] m_value;
        bit          m_txn, m_req, m_pend, m_valid, m_change, m_terr, m_set, m_start;
        int          m_edge, m_idle, m_stall, m_acc;

        initial begin
            forever begin
                @(posedge clk or posedge reset);
                if (reset) begin
                    m_value = '0; m_txn = 0; m_req = 0; m_pend = 0; m_valid = 0;
                    m_change = 0; m_terr = 0; m_edge = 0; m_idle = 0; m_stall = 0; m_acc = 0;
                end else begin
                    m_edge++;
                    m_change = 1'b0;
                    m_set    = 1'b0;
                    m_start  = 1'b0;
                    if (!m_txn) begin
                        if ((enable && m_idle == PERIOD - 1) || m_pend) begin
                            m_start = 1; m_txn = 1; m_req = 1; m_idle = 0; m_stall = 0;
                        end else if (enable) begin
                            m_idle++;
                        end
                    end else if (m_req) begin
                        if (avm_waitrequest) begin
                            if (m_stall < TIMEOUT) begin
                                m_stall++;
                                m_set = (m_stall == TIMEOUT);
                            end
                        end else begin
                            m_req = 0;
                            m_acc = m_edge;
                        end
                    end
                    if (m_txn && !m_req && m_edge == m_acc + RL) begin
                        m_change = m_valid && (avm_readdata != m_value);
                        m_value  = avm_readdata;
                        m_valid  = 1'b1;
                        m_txn    = 1'b0;
                    end
                    m_pend = m_start ? 1'b0 : (m_pend | force_poll);
                    if (m_set) m_terr = 1'b1;
                    else if (clear_err) m_terr = 1'b0;
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                chk1($sformatf("m%0d_read", gi), read_w[gi], m_req);
                chk($sformatf("m%0d_addr", gi), DW'(addr_w[gi]), DW'(PADDR));
                chk($sformatf("m%0d_value", gi), value_w[gi], m_value);
                chk1($sformatf("m%0d_valid", gi), valid_w[gi], m_valid);
                chk1($sformatf("m%0d_change", gi), change_w[gi], m_change);
                chk1($sformatf("m%0d_busy", gi), busy_w[gi], m_txn);
                chk1($sformatf("m%0d_terr", gi), terr_w[gi], m_terr);
            end
        end
    end

    initial begin
        int n;
        int rises;
        reset = 1'b1; enable = 1'b0; force_poll = 1'b0; clear_err = 1'b0;
        avm_waitrequest = 1'b0; avm_readdata = '0;
        repeat (3) @(negedge clk);

        chk1("rst_read", read_w[1], 1'b0);
        chk1("rst_valid", valid_w[1], 1'b0);
        chk("rst_value", value_w[1], 32'h0);
        chk1("rst_busy", busy_w[1], 1'b0);
        chk1("rst_terr", terr_w[1], 1'b0);
        chk("rst_addr", DW'(addr_w[1]), DW'(PADDR));
        $display("txn reset checked");

        // First poll after release, 1-cycle read pulse, sample two cycles later.
        avm_readdata = 32'h5; enable = 1'b1; reset = 1'b0;
        wait_read(1, n);
        chk("first_read_cycle", n, PERIOD);
        tick();
        chk1("pulse_width", read_w[1], 1'b0);
        tick();
        chk("first_value", value_w[1], 32'h5);
        chk1("first_valid", valid_w[1], 1'b1);
        chk1("first_no_change", change_w[1], 1'b0);
        $display("txn first poll value=%0h", value_w[1]);

        avm_readdata = 32'h7;
        wait_read(1, n);
        chk("b2b_spacing", n + 2, PERIOD + 2);
        tick(); tick();
        chk("value7", value_w[1], 32'h7);
        chk1("change_pulse", change_w[1], 1'b1);
        tick();
        chk1("change_one_cycle", change_w[1], 1'b0);
        wait_read(1, n);
        tick(); tick();
        chk("value7_again", value_w[1], 32'h7);
        chk1("no_change_same", change_w[1], 1'b0);
        $display("txn change poll value=%0h", value_w[1]);

        // Five stalled edges, timeout at the third (clear_err on that edge loses).
        avm_readdata = 32'h3; avm_waitrequest = 1'b1;
        wait_read(1, n);
        for (int s = 1; s <= 5; s++) begin
            clear_err = (s == 3);
            tick();
            chk1("stall_read", read_w[1], 1'b1);
            chk("stall_addr", DW'(addr_w[1]), DW'(PADDR));
            chk1("stall_terr", terr_w[1], s >= 3);
        end
        clear_err = 1'b0; avm_waitrequest = 1'b0;
        tick();
        chk1("accept_read", read_w[1], 1'b0);
        tick();
        chk("stall_value", value_w[1], 32'h3);
        chk1("terr_sticky", terr_w[1], 1'b1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk1("terr_cleared", terr_w[1], 1'b0);
        $display("txn stall poll value=%0h", value_w[1]);

        // Disabled: forced poll, two force pulses during it collapse to one extra poll.
        enable = 1'b0; avm_readdata = 32'h9;
        count_rises(1, 8, rises);
        chk("disabled_polls", rises, 0);
        force_poll = 1'b1;
        tick();
        force_poll = 1'b0;
        wait_read(1, n);
        chk("force_latency", n, 1);
        force_poll = 1'b1;
        tick(); tick();
        force_poll = 1'b0;
        count_rises(1, 40, rises);
        chk("extra_polls", rises, 1);
        $display("txn forced polls extra=%0d", rises);

        // Asynchronous reset while waiting for data, and while requesting.
        enable = 1'b1; avm_readdata = 32'hC;
        wait_read(1, n);
        tick();
        chk1("lat_busy", busy_w[1], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("rst_async_busy", busy_w[1], 1'b0);
        chk1("rst_async_valid", valid_w[1], 1'b0);
        chk("rst_async_value", value_w[1], 32'h0);
        chk1("rst_async_change", change_w[1], 1'b0);
        chk1("rst_async_read", read_w[1], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        wait_read(1, n);
        chk("post_reset_first", n, PERIOD);
        #2 reset = 1'b1;
        #1;
        chk1("rst_req_read", read_w[1], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset mid-transaction");

        for (int c = 0; c < 600; c++) begin
            enable          = ($urandom_range(0, 9) != 0);
            force_poll      = ($urandom_range(0, 15) == 0);
            clear_err       = ($urandom_range(0, 11) == 0);
            avm_waitrequest = ($urandom_range(0, 2) == 0);
            avm_readdata    = 32'($urandom_range(0, 3));
            tick();
            if (c == 300) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        $display("txn random phase done checks=%0d", checks);

        enable = 1'b1; force_poll = 1'b0; clear_err = 1'b0; avm_waitrequest = 1'b0;
        lat_check(0, 0);
        lat_check(2, 3);
        lat_check(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
